apb_cmd_master: RTL and testbench

APB master that turns a valid/ready command stream into single APB transfers and returns one response per command on a valid/ready response stream. It sits between a firmware-facing command source (or a boot-time config sequencer) and APB config slaves such as the DMA config register blocks, so the fabric can program start/length/burst/valid registers and poll status without a CPU bus. It handles slave wait states and slave errors, and a timeout guards against a hung slave.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_cmd_master.sv | 153 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states, response codes and an address helper
// used by config sequencers.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  localparam logic [1:0] RspOk      = 2'd0;
  localparam logic [1:0] RspSlvErr  = 2'd1;
  localparam logic [1:0] RspTimeout = 2'd2;

  // Register index (32-bit words) to APB byte address.
  function automatic logic [31:0] word_to_byte(input logic [29:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/apb_cmd_master.sv
// APB master: one valid/ready command becomes one APB transfer and exactly one response,
// with wait-state handling, slave error reporting and an optional hung-slave timeout.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned AddrBits      = 6,
  parameter int unsigned DataBits      = 32,
  parameter int unsigned TimeoutBits   = 8,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AddrBits-1:0] cmd_addr,
  input  logic [DataBits-1:0] cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DataBits-1:0] rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic [AddrBits-1:0] paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DataBits-1:0] pwdata,
  input  logic                pready,
  input  logic [DataBits-1:0] prdata,
  input  logic                pslverr,
  output logic                busy
);

  localparam bit TimeoutEn = (TimeoutCycles != 0);
  localparam logic [TimeoutBits-1:0] TimeoutLast =
      (TimeoutCycles == 0) ? '0 : TimeoutBits'(TimeoutCycles - 1);

  apb_state_e state_q, state_d;

  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DataBits-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]             rsp_err_q, rsp_err_d;
  logic [AddrBits-1:0]    paddr_q, paddr_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [DataBits-1:0]    pwdata_q, pwdata_d;
  logic                   busy_q, busy_d;
  logic [TimeoutBits-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        // A completing slave wins over a timeout landing in the same cycle.
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr ? RspSlvErr : RspOk;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = StResp;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = RspTimeout;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= RspOk;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: behavioural APB register slave, reference memory model and
// per-scenario tasks with inline checks.
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready;
  logic [AW-1:0] cmd_addr, paddr;
  logic [DW-1:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  logic [1:0]    rsp_err;
  logic          psel, penable, pwrite, pready, pslverr, busy;

  apb_cmd_master #(
    .AddrBits(AW), .DataBits(DW), .TimeoutBits(8), .TimeoutCycles(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy)
  );

  // Second instance with the timeout disabled and a slave that never answers.
  logic          nt_cmd_valid, nt_cmd_ready, nt_cmd_write, nt_rsp_valid, nt_rsp_ready;
  logic [AW-1:0] nt_cmd_addr, nt_paddr;
  logic [DW-1:0] nt_cmd_wdata, nt_rsp_rdata, nt_pwdata, nt_prdata;
  logic [1:0]    nt_rsp_err;
  logic          nt_psel, nt_penable, nt_pwrite, nt_pready, nt_pslverr, nt_busy;

  apb_cmd_master #(
    .AddrBits(AW), .DataBits(DW), .TimeoutBits(8), .TimeoutCycles(0)
  ) dut_nt (
    .clk(clk), .rst_n(rst_n), .cmd_valid(nt_cmd_valid), .cmd_ready(nt_cmd_ready),
    .cmd_write(nt_cmd_write), .cmd_addr(nt_cmd_addr), .cmd_wdata(nt_cmd_wdata),
    .rsp_valid(nt_rsp_valid), .rsp_ready(nt_rsp_ready), .rsp_rdata(nt_rsp_rdata),
    .rsp_err(nt_rsp_err), .paddr(nt_paddr), .psel(nt_psel), .penable(nt_penable),
    .pwrite(nt_pwrite), .pwdata(nt_pwdata), .pready(nt_pready), .prdata(nt_prdata),
    .pslverr(nt_pslverr), .busy(nt_busy)
  );

  // Behavioural slave: 16 word registers, programmable wait states and error flag.
  logic [DW-1:0] mem [16];
  int unsigned   waits;
  logic          hold_low, err_flag;
  logic [7:0]    acc_cnt;

  assign pready  = psel && penable && !hold_low && (32'(acc_cnt) >= waits);
  assign pslverr = pready && err_flag;
  assign prdata  = mem[paddr[5:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      acc_cnt <= '0;
    end else begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 8'd1;
      else acc_cnt <= '0;
      if (pready && pwrite && !err_flag) mem[paddr[5:2]] <= pwdata;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [16];
  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    err;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command from IDLE and returns when rsp_valid is first seen (not yet consumed).
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int unsigned nw, input logic er, output int lat, output int acc,
                         output logic stable, output logic phase_ok, output logic hung);
    waits = nw;
    err_flag = er;
    cmd_write = wr;
    cmd_addr = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    acc = 0;
    stable = 1'b1;
    phase_ok = 1'b1;
    hung = 1'b0;
    while (!rsp_valid) begin
      if (lat == 0 && !(psel && !penable && busy && !cmd_ready)) phase_ok = 1'b0;
      if (lat == 1 && !(psel && penable)) phase_ok = 1'b0;
      if (psel && (paddr !== addr || pwrite !== wr || pwdata !== wd)) stable = 1'b0;
      if (psel && penable) acc++;
      if (lat > 300) begin
        hung = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors += 8;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
    if (psel !== 1'b0) begin miscompares++; $display("FAIL reset_psel got %0b want 0", psel); end
    if (penable !== 1'b0) begin miscompares++; $display("FAIL reset_penable got %0b want 0", penable); end
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (rsp_rdata !== '0 || rsp_err !== 2'd0) begin miscompares++; $display("FAIL reset_rsp got %h/%0d want 0/0", rsp_rdata, rsp_err); end
    if (paddr !== '0 || pwdata !== '0) begin miscompares++; $display("FAIL reset_apb_bus got %h/%h want 0/0", paddr, pwdata); end
    if (pwrite !== 1'b0) begin miscompares++; $display("FAIL reset_pwrite got %0b want 0", pwrite); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_basic();
    int lat, acc;
    logic stable, phase_ok, hung;
    run_cmd(1'b1, 6'h04, 32'h100, 0, 1'b0, lat, acc, stable, phase_ok, hung);
    ref_mem[1] = 32'h100;
    vectors += 6;
    if (hung || lat != 2) begin miscompares++; $display("FAIL wr_latency got %0d want 2", lat); end
    if (!phase_ok) begin miscompares++; $display("FAIL wr_phases got bad want psel@1 penable@2"); end
    if (!stable) begin miscompares++; $display("FAIL wr_bus_stable got unstable want addr 04 data 100 write"); end
    if (rsp_err !== RspOk || rsp_rdata !== '0) begin miscompares++; $display("FAIL wr_rsp got %0d/%h want 0/0", rsp_err, rsp_rdata); end
    if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL wr_resp_state got psel %0b pen %0b rdy %0b want 0 0 0", psel, penable, cmd_ready); end
    tick();
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL wr_return_idle got v%0b r%0b b%0b want 0 1 0", rsp_valid, cmd_ready, busy); end
    if (mem[1] !== ref_mem[1]) begin miscompares++; $display("FAIL wr_slave_reg got %h want %h", mem[1], ref_mem[1]); end
    vectors++;
  endtask

  task automatic test_read_random();
    int lat, acc;
    logic stable, phase_ok, hung;
    logic [31:0] ba;
    run_cmd(1'b1, 6'h0C, 32'h1, 0, 1'b0, lat, acc, stable, phase_ok, hung);
    ref_mem[3] = 32'h1;
    tick();
    run_cmd(1'b0, 6'h0C, 32'h0, 0, 1'b0, lat, acc, stable, phase_ok, hung);
    vectors += 2;
    if (rsp_rdata[0] !== 1'b1 || rsp_rdata !== ref_mem[3]) begin miscompares++; $display("FAIL rd_dma_cfg got %h want %h", rsp_rdata, ref_mem[3]); end
    if (!stable) begin miscompares++; $display("FAIL rd_paddr_stable got unstable want 0c"); end
    tick();
    for (int i = 0; i < 10; i++) begin
      logic wr, er;
      logic [3:0] idx;
      logic [DW-1:0] wd, exp_rd;
      int unsigned nw;
      wr = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      wd = $urandom;
      nw = $urandom_range(0, 4);
      er = ($urandom_range(0, 3) == 0);
      ba = word_to_byte(30'(idx));
      exp_rd = wr ? '0 : ref_mem[idx];
      run_cmd(wr, ba[AW-1:0], wd, nw, er, lat, acc, stable, phase_ok, hung);
      if (wr && !er) ref_mem[idx] = wd;
      vectors += 3;
      if (hung || lat != int'(nw) + 2 || acc != int'(nw) + 1) begin miscompares++; $display("FAIL rnd%0d_timing got lat %0d acc %0d want %0d %0d", i, lat, acc, nw + 2, nw + 1); end
      if (rsp_rdata !== exp_rd || rsp_err !== {1'b0, er}) begin miscompares++; $display("FAIL rnd%0d_rsp got %h/%0d want %h/%0d", i, rsp_rdata, rsp_err, exp_rd, er); end
      if (!stable) begin miscompares++; $display("FAIL rnd%0d_bus_stable got unstable want stable", i); end
      tick();
    end
  endtask

  task automatic test_wait_err();
    int lat, acc;
    logic stable, phase_ok, hung;
    run_cmd(1'b0, 6'h0C, 32'h0, 3, 1'b1, lat, acc, stable, phase_ok, hung);
    vectors += 3;
    if (hung || lat != 5) begin miscompares++; $display("FAIL wait3_latency got %0d want 5", lat); end
    if (acc != 4) begin miscompares++; $display("FAIL wait3_access_cycles got %0d want 4", acc); end
    if (rsp_err !== RspSlvErr || rsp_rdata !== ref_mem[3]) begin miscompares++; $display("FAIL wait3_slverr got %0d/%h want 1/%h", rsp_err, rsp_rdata, ref_mem[3]); end
    err_flag = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int lat, acc;
    logic stable, phase_ok, hung;
    hold_low = 1'b1;
    run_cmd(1'b0, 6'h08, 32'h0, 0, 1'b0, lat, acc, stable, phase_ok, hung);
    vectors += 3;
    if (hung || acc != 16 || lat != 17) begin miscompares++; $display("FAIL timeout_cycles got acc %0d lat %0d want 16 17", acc, lat); end
    if (rsp_err !== RspTimeout || rsp_rdata !== '0) begin miscompares++; $display("FAIL timeout_rsp got %0d/%h want 2/0", rsp_err, rsp_rdata); end
    if (psel !== 1'b0 || penable !== 1'b0) begin miscompares++; $display("FAIL timeout_psel got %0b/%0b want 0/0", psel, penable); end
    hold_low = 1'b0;
    tick();
  endtask

  task automatic test_no_timeout();
    nt_cmd_write = 1'b1;
    nt_cmd_addr = 6'h14;
    nt_cmd_wdata = 32'hA5A5;
    nt_cmd_valid = 1'b1;
    tick();
    nt_cmd_valid = 1'b0;
    repeat (101) tick();
    vectors += 3;
    if (nt_psel !== 1'b1 || nt_penable !== 1'b1 || nt_busy !== 1'b1 || nt_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL notimeout_state got sel %0b en %0b busy %0b rv %0b want 1 1 1 0", nt_psel, nt_penable, nt_busy, nt_rsp_valid); end
    if (nt_paddr !== 6'h14 || nt_pwdata !== 32'hA5A5 || nt_pwrite !== 1'b1) begin miscompares++; $display("FAIL notimeout_bus got %h/%h/%0b want 14/a5a5/1", nt_paddr, nt_pwdata, nt_pwrite); end
    if (nt_cmd_ready !== 1'b0 || nt_rsp_rdata !== '0 || nt_rsp_err !== 2'd0) begin miscompares++; $display("FAIL notimeout_rsp got %0b/%h/%0d want 0/0/0", nt_cmd_ready, nt_rsp_rdata, nt_rsp_err); end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    fork
      begin : driver
        for (int i = 0; i < 8; i++) begin
          int bound;
          logic wr, er;
          logic [3:0] idx;
          logic [DW-1:0] wd;
          exp_t e;
          bound = 0;
          while (!cmd_ready && bound < 300) begin tick(); bound++; end
          if (bound >= 300) begin
            miscompares++;
            $display("FAIL b2b_cmd_ready got 0 want 1 within 300 cycles");
            break;
          end
          wr = 1'($urandom_range(0, 1));
          idx = 4'($urandom_range(0, 15));
          wd = $urandom;
          er = ($urandom_range(0, 4) == 0);
          waits = $urandom_range(0, 2);
          err_flag = er;
          cmd_write = wr;
          cmd_addr = {idx, 2'b00};
          cmd_wdata = wd;
          cmd_valid = 1'b1;
          e.rdata = wr ? '0 : ref_mem[idx];
          e.err = {1'b0, er};
          if (wr && !er) ref_mem[idx] = wd;
          exp_q.push_back(e);
          tick();
          cmd_valid = 1'b0;
        end
      end
      begin : monitor
        int got, cyc;
        logic held, rr;
        logic [DW-1:0] h_rd;
        logic [1:0] h_err;
        got = 0;
        cyc = 0;
        held = 1'b0;
        h_rd = '0;
        h_err = '0;
        while (got < 8 && cyc < 3000) begin
          if (held) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== h_rd || rsp_err !== h_err) begin miscompares++; $display("FAIL b2b_hold got v%0b %h/%0d want 1 %h/%0d", rsp_valid, rsp_rdata, rsp_err, h_rd, h_err); end
          end
          rr = 1'($urandom_range(0, 1));
          rsp_ready = rr;
          held = 1'b0;
          if (rsp_valid) begin
            if (rr) begin
              exp_t e;
              vectors++;
              if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_extra_rsp got %h/%0d want none", rsp_rdata, rsp_err);
              end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin miscompares++; $display("FAIL b2b_rsp%0d got %h/%0d want %h/%0d", got, rsp_rdata, rsp_err, e.rdata, e.err); end
              end
              got++;
            end else begin
              held = 1'b1;
              h_rd = rsp_rdata;
              h_err = rsp_err;
            end
          end
          tick();
          cyc++;
        end
        vectors++;
        if (got != 8 || exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_count got %0d left %0d want 8 0", got, exp_q.size()); end
      end
    join
    rsp_ready = 1'b1;
    err_flag = 1'b0;
    waits = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, acc;
    logic stable, phase_ok, hung;
    hold_low = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 6'h10;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (psel !== 1'b1 || penable !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got %0b/%0b want 1/1", psel, penable); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_async got sel %0b en %0b rv %0b busy %0b rdy %0b want 0 0 0 0 1", psel, penable, rsp_valid, busy, cmd_ready);
    end
    #2 rst_n = 1'b1;
    hold_low = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    tick();
    run_cmd(1'b1, 6'h3C, 32'hDEADBEEF, 1, 1'b0, lat, acc, stable, phase_ok, hung);
    ref_mem[15] = 32'hDEADBEEF;
    vectors++;
    if (hung || lat != 3 || rsp_err !== RspOk) begin miscompares++; $display("FAIL rstmid_next_wr got lat %0d err %0d want 3 0", lat, rsp_err); end
    tick();
    run_cmd(1'b0, 6'h3C, 32'h0, 0, 1'b0, lat, acc, stable, phase_ok, hung);
    vectors++;
    if (hung || rsp_rdata !== ref_mem[15]) begin miscompares++; $display("FAIL rstmid_next_rd got %h want %h", rsp_rdata, ref_mem[15]); end
    tick();
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    waits = 0;
    hold_low = 1'b0;
    err_flag = 1'b0;
    nt_cmd_valid = 1'b0;
    nt_cmd_write = 1'b0;
    nt_cmd_addr = '0;
    nt_cmd_wdata = '0;
    nt_rsp_ready = 1'b1;
    nt_pready = 1'b0;
    nt_prdata = '0;
    nt_pslverr = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    test_reset();
    test_write_basic();
    test_read_random();
    test_wait_err();
    test_timeout();
    test_no_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
